// File: rtl/pwm_pkg.sv
// Shared types for the multi-channel PWM generator: modulation mode and
// counter direction encodings.
package pwm_pkg;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/pwm_chan.sv
// One PWM channel: double-buffered duty register with write decode, and the
// registered compare against the shared period counter.
module pwm_chan
  import pwm_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int CH_W   = 1,
  parameter int CH_IDX = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load_act,
  input  logic [WIDTH-1:0] cnt,
  input  logic             duty_wr,
  input  logic [CH_W-1:0]  duty_ch,
  input  logic [WIDTH-1:0] duty_val,
  output logic             pwm
);

  localparam logic [CH_W-1:0] MY_IDX = CH_W'(CH_IDX);

  logic             wr_hit;
  logic [WIDTH-1:0] duty_pend;
  logic [WIDTH-1:0] duty_act;
  logic [WIDTH-1:0] duty_src;

  // A write landing in a load cycle goes straight to the active copy.
  assign wr_hit   = duty_wr && (duty_ch == MY_IDX);
  assign duty_src = wr_hit ? duty_val : duty_pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      duty_pend <= '0;
      duty_act  <= '0;
      pwm       <= 1'b0;
    end else begin
      if (wr_hit) begin
        duty_pend <= duty_val;
      end
      if (load_act) begin
        duty_act <= duty_src;
      end
      pwm <= en && (cnt < duty_act);
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: shared edge/center-aligned period counter with
// boundary-latched period and mode, feeding CHANNELS compare channels.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 2,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                center,
  input  logic [WIDTH-1:0]    period,
  input  logic                duty_wr,
  input  logic [CH_W-1:0]     duty_ch,
  input  logic [WIDTH-1:0]    duty_val,
  output logic [CHANNELS-1:0] PWM_sig,
  output logic                period_start
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_nxt;
  logic [WIDTH-1:0] period_act;
  logic             dir;
  logic             dir_nxt;
  pwm_mode_e        center_act;
  logic             boundary;
  logic             load_act;

  // Next count and boundary detect; cnt never exceeds period_act, so the
  // increment cannot overflow even at P = all ones.
  always_comb begin
    cnt_nxt  = cnt;
    dir_nxt  = dir;
    boundary = 1'b0;
    if (period_act == '0) begin
      boundary = 1'b1;
    end else if (center_act == PWM_EDGE) begin
      if (cnt >= period_act) begin
        boundary = 1'b1;
      end else begin
        cnt_nxt = cnt + ONE;
      end
    end else if (dir == DIR_UP) begin
      if (cnt < period_act) begin
        cnt_nxt = cnt + ONE;
      end else if (period_act == ONE) begin
        boundary = 1'b1;
      end else begin
        cnt_nxt = cnt - ONE;
        dir_nxt = DIR_DOWN;
      end
    end else begin
      if (cnt <= ONE) begin
        boundary = 1'b1;
      end else begin
        cnt_nxt = cnt - ONE;
      end
    end
    if (boundary) begin
      cnt_nxt = '0;
      dir_nxt = DIR_UP;
    end
  end

  // While idle the active copies track their inputs so enable starts clean.
  assign load_act = !en || boundary;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      dir          <= DIR_UP;
      period_act   <= '1;
      center_act   <= PWM_EDGE;
      period_start <= 1'b0;
    end else if (!en) begin
      cnt          <= '0;
      dir          <= DIR_UP;
      period_act   <= period;
      center_act   <= pwm_mode_e'(center);
      period_start <= 1'b0;
    end else begin
      cnt          <= cnt_nxt;
      dir          <= dir_nxt;
      period_start <= boundary;
      if (boundary) begin
        period_act <= period;
        center_act <= pwm_mode_e'(center);
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    pwm_chan #(
      .WIDTH  (WIDTH),
      .CH_W   (CH_W),
      .CH_IDX (c)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .load_act (load_act),
      .cnt      (cnt),
      .duty_wr  (duty_wr),
      .duty_ch  (duty_ch),
      .duty_val (duty_val),
      .pwm      (PWM_sig[c])
    );
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi: period-position reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pwm_multi;

  localparam int WIDTH = 8;
  localparam int CH    = 3;
  localparam int CH_W  = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             center;
  logic [WIDTH-1:0] period;
  logic             duty_wr;
  logic [CH_W-1:0]  duty_ch;
  logic [WIDTH-1:0] duty_val;
  logic [CH-1:0]    PWM_sig;
  logic             period_start;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pwm_multi #(.WIDTH(WIDTH), .CHANNELS(CH)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .center       (center),
    .period       (period),
    .duty_wr      (duty_wr),
    .duty_ch      (duty_ch),
    .duty_val     (duty_val),
    .PWM_sig      (PWM_sig),
    .period_start (period_start)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: position k inside the current period, plus the active
  // period/mode/duties; the counter value is derived from k arithmetically.
  int            m_k, m_P, m_C;
  int            m_act [CH];
  int            m_pend[CH];
  logic [CH-1:0] exp_pwm;
  logic          exp_ps;
  logic          model_ok = 1'b0;

  function automatic int per_len(input int p, input int c);
    if (p == 0) return 1;
    return (c != 0) ? 2 * p : p + 1;
  endfunction

  function automatic int cnt_at(input int k, input int p, input int c);
    if (c != 0 && k > p) return 2 * p - k;
    return k;
  endfunction

  int            np[CH];
  int            cv;
  logic          last;
  logic [CH-1:0] pw;

  always_comb begin
    for (int i = 0; i < CH; i++) np[i] = m_pend[i];
    if (duty_wr && int'(duty_ch) < CH) np[int'(duty_ch)] = int'(duty_val);
    cv   = cnt_at(m_k, m_P, m_C);
    last = (m_k == per_len(m_P, m_C) - 1);
    pw   = '0;
    for (int i = 0; i < CH; i++) pw[i] = en && (cv < m_act[i]);
  end

  always @(posedge clk) begin
    if (rst) begin
      m_k      <= 0;
      m_P      <= (1 << WIDTH) - 1;
      m_C      <= 0;
      exp_pwm  <= '0;
      exp_ps   <= 1'b0;
      model_ok <= 1'b1;
      for (int i = 0; i < CH; i++) begin
        m_act[i]  <= 0;
        m_pend[i] <= 0;
      end
    end else begin
      exp_pwm <= pw;
      exp_ps  <= en && last;
      m_k     <= (en && !last) ? m_k + 1 : 0;
      for (int i = 0; i < CH; i++) m_pend[i] <= np[i];
      if (!en || last) begin
        m_P <= int'(period);
        m_C <= int'(center);
        for (int i = 0; i < CH; i++) m_act[i] <= np[i];
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      for (int i = 0; i < CH; i++)
        check($sformatf("pwm_ch%0d", i), int'(PWM_sig[i]), int'(exp_pwm[i]));
      check("period_start", int'(period_start), int'(exp_ps));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int ch, input int val);
    @(negedge clk);
    duty_wr  = 1'b1;
    duty_ch  = CH_W'(ch);
    duty_val = WIDTH'(val);
    @(negedge clk);
    duty_wr  = 1'b0;
  endtask

  task automatic wait_ps();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if (period_start) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("ps_timeout", 0, 1);
  endtask

  // Samples one full period of channel ch starting at a period_start cycle.
  task automatic measure(input int ch, input int len, input logic at_ps,
                         output int high, output logic [15:0] pat);
    int early;
    high  = 0;
    pat   = '0;
    early = 0;
    if (!at_ps) wait_ps();
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (PWM_sig[ch]) begin
        high++;
        if (i < 16) pat[i] = 1'b1;
      end
      if (i < len - 1 && period_start) early++;
    end
    check("ps_early", early, 0);
    check("ps_at_end", int'(period_start), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int            high;
    int            cyc;
    logic [15:0]   pat;

    rst = 1'b1; en = 1'b0; center = 1'b0; duty_wr = 1'b0;
    duty_ch = '0; duty_val = '0; period = 8'd255;
    tick(3);
    check("rst_pwm", int'(PWM_sig), 0);
    check("rst_ps", int'(period_start), 0);

    // Default period after reset, D = 140 lands in the second period.
    rst = 1'b0; en = 1'b1;
    wr(0, 140);
    high = 0;
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      if (PWM_sig[0]) high++;
    end
    check("first_period_low", high, 0);
    measure(0, 256, 1'b0, high, pat);
    check("d140_high", high, 140);

    // Duty extremes at P = 9 (writes while idle load directly).
    en = 1'b0; period = 8'd9; center = 1'b0;
    wr(0, 0); wr(1, 10); wr(2, 3);
    en = 1'b1;
    measure(0, 10, 1'b0, high, pat);
    check("d0_high", high, 0);
    measure(1, 10, 1'b1, high, pat);
    check("d10_high", high, 10);
    measure(2, 10, 1'b1, high, pat);
    check("d3_high", high, 3);

    // Center mode P = 4, D = 2.
    center = 1'b1; period = 8'd4;
    wr(0, 2);
    measure(0, 8, 1'b0, high, pat);
    check("center_high", high, 3);
    check("center_pattern", int'(pat[7:0]), 8'b1000_0011);

    // Shadowing: last write before the boundary wins for the next period.
    center = 1'b0; period = 8'd9;
    wait_ps();
    wr(0, 5); tick(2); wr(0, 7);
    measure(0, 10, 1'b0, high, pat);
    check("shadow_high", high, 7);
    // Write in the boundary cycle (cnt = P) applies at that boundary.
    tick(9);
    duty_wr = 1'b1; duty_ch = 2'd0; duty_val = 8'd4;
    @(negedge clk);
    duty_wr = 1'b0;
    measure(0, 10, 1'b1, high, pat);
    check("bypass_high", high, 4);

    // Disable mid-period, then re-enable for a full period.
    tick(4);
    en = 1'b0;
    @(negedge clk);
    check("dis_pwm", int'(PWM_sig), 0);
    check("dis_ps", int'(period_start), 0);
    tick(2);
    en = 1'b1;
    cyc = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (period_start) begin
        cyc = i;
        break;
      end
    end
    check("reenable_len", cyc, 10);

    // Reset pulse mid-period.
    tick(3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_pwm", int'(PWM_sig), 0);
    check("midrst_ps", int'(period_start), 0);

    // Invalid channel index and P = 0.
    en = 1'b0; period = 8'd0;
    wr(0, 0); wr(1, 1); wr(2, 200); wr(3, 0);
    en = 1'b1;
    tick(2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("p0_pwm", int'(PWM_sig), 6);
      check("p0_ps", int'(period_start), 1);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 5000; n++) begin
      @(negedge clk);
      duty_wr = ($urandom_range(0, 3) == 0);
      duty_ch = CH_W'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) duty_val = WIDTH'($urandom_range(0, 255));
      else duty_val = WIDTH'($urandom_range(0, 14));
      if ($urandom_range(0, 39) == 0) begin
        if ($urandom_range(0, 7) == 0) period = WIDTH'($urandom_range(0, 255));
        else period = WIDTH'($urandom_range(0, 12));
        center = $urandom_range(0, 1) == 1;
      end
      if (en && $urandom_range(0, 299) == 0) en = 1'b0;
      else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
      rst = ($urandom_range(0, 999) == 0);
    end
    duty_wr = 1'b0;
    rst = 1'b0;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_multi.md
# pwm_multi

Parametrised multi-channel PWM generator for motor and servo drive: one shared period counter, per-channel programmable duty with shadow (double-buffered) registers, and selectable edge- or center-aligned modulation. It generalises the fixed 8-bit, fixed-duty generator in width, channel count and mode. Sits between the control logic that computes duty values and the motor driver pins.

## Interface
- `WIDTH`, 8: counter, period and duty width in bits.
- `CHANNELS`, 2: number of PWM outputs. Must be ≥1.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  run enable.
- `center`  in  1  mode select: 0 = edge-aligned, 1 = center-aligned. Sampled at the period boundary.
- `period`  in  WIDTH  period value P. Sampled at the period boundary.
- `duty_wr`  in  1  one-cycle strobe that writes the pending duty of one channel.
- `duty_ch`  in  max(1,$clog2(CHANNELS))  channel index for `duty_wr`. Writes with an index ≥ CHANNELS are ignored.
- `duty_val`  in  WIDTH  duty value D.
- `PWM_sig`  out  CHANNELS  registered PWM outputs, one bit per channel.
- `period_start`  out  1  registered one-cycle pulse on the first cycle of each period.

## Operation
- **Registers:** counter `cnt`; direction bit `dir` (center mode only); and the active copies `period_act`, `center_act` and `duty_act[c]`. Each channel also has a `duty_pend[c]` register.
- **Edge mode:**
  - `cnt` counts 0, 1, …, P, then wraps to 0. The period is P+1 cycles.
  - P = 0 holds `cnt` at 0 and gives a 1-cycle period.
- **Center mode:**
  - `cnt` counts 0 up to P, then P−1 down to 1, then back to 0. The period is 2P cycles.
  - P = 0 holds `cnt` at 0 and gives a 1-cycle period.
- **Boundary cycle:** the cycle in which the next `cnt` value is the start of a new period (next `cnt` = 0 and a new period begins).
  - In that cycle: `period_act` ← `period`; `center_act` ← `center`; `duty_act[c]` ← `duty_pend[c]`.
  - `dir` is reset to up.
- **Duty writes:**
  - `duty_wr` loads `duty_pend[duty_ch]` in any cycle.
  - A write in the boundary cycle bypasses the pending register and reaches `duty_act` at that same boundary.
- **Compare:** next `PWM_sig[c]` = (`cnt` < `duty_act[c]`).
  - D = 0 gives a constant low output.
  - Edge mode: D ≥ P+1 gives a constant high output.
  - Center mode: D > P gives a constant high output.
  - Center-mode pulses are symmetric about `cnt` = P.
- **`period_start`:** next value = boundary cycle condition, so it is high in the cycle where `cnt` = 0 starts a period.
- **Enable:**
  - `en` = 0: `cnt` ← 0, `dir` ← up, `PWM_sig` ← 0, `period_start` ← 0.
  - While `en` = 0, the active registers load every cycle (as at a boundary).
  - On `en` rising, the first period starts at `cnt` = 0 with the latest `period`, `center` and pending duties.
- **Arithmetic:** unsigned compares at WIDTH bits. No intermediate exceeds WIDTH bits; P = 2^WIDTH−1 is legal.

## Timing
- **Reset values:**
  - `cnt` = 0, `dir` = up, `duty_pend` = 0, `duty_act` = 0.
  - `period_act` = all ones, `center_act` = 0.
  - `PWM_sig` = 0, `period_start` = 0.
- Reset overrides `en` and `duty_wr`. Reset asserted mid-period forces these values on the next edge.
- **Output latency:** `PWM_sig` is 1 cycle behind `cnt`. The period boundary is visible on `PWM_sig` 1 cycle after `cnt` = 0.
- **Write-to-output latency:** a duty write never affects the current period. The earliest effect is the first output cycle of the next period.
- Changes to `period` and `center` between boundaries have no effect.

## Structure
- Shared package `pwm_pkg` contains:
  - enum `pwm_mode_e` {`PWM_EDGE`, `PWM_CENTER`};
  - the direction constants.
- One sub-module, `pwm_chan`, instantiated CHANNELS times. It holds `duty_pend`, `duty_act`, the write decode and the compare/output flop.
- The top level holds `cnt`, `dir`, the boundary detect, the active period/mode registers and `period_start`.

## Test plan
- **Reset and default period:** reset, `en` = 1, P = 255, edge mode, write D = 140 to ch0 → ch0 stays low for 256 cycles, then from the next period is high for 140 cycles and low for 116; `period_start` fires every 256 cycles.
- **Duty extremes:** P = 9, edge mode, ch0 D = 0, ch1 D = 10 → ch0 constantly 0, ch1 constantly 1; D = 3 → high 3 cycles, low 7.
- **Center mode:** P = 4, D = 2 → period 8 (`cnt` 0,1,2,3,4,3,2,1); `PWM_sig` high 3 of 8 cycles, symmetric.
- **Shadowing:** write D = 5 mid-period, then D = 7 before the boundary → the current period is unchanged and the next period uses 7. A write in the boundary cycle applies immediately at that boundary.
- **Disable and reset mid-period:** `en` dropped mid-period → outputs 0 and `cnt` 0 next cycle; re-enable starts a full period. `rst` pulse mid-period → all reset values on the next edge.
- **Invalid channel and P = 0:** `duty_wr` with index ≥ CHANNELS → no channel changes. P = 0 → `period_start` every cycle, outputs high iff D ≥ 1.
